// File: rtl/insn_encode.sv
// ============================================================================
// insn_encode : packs RV32I instruction fields into 32-bit words, range-checks
//               immediates, tags each word with a sequential PC, 2-entry FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module insn_encode #(
  parameter int                 DWIDTH    = 32,
  parameter int                 AWIDTH    = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h0100_0000,
  parameter int                 ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [6:0]          opcode_i,
  input  logic [4:0]          rd_i,
  input  logic [4:0]          rs1_i,
  input  logic [4:0]          rs2_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  input  logic [4:0]          shamt_i,
  input  logic [DWIDTH-1:0]   imm_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [AWIDTH-1:0]   pc_o,
  output logic [DWIDTH-1:0]   insn_o,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  localparam logic [6:0]        c_OP_R     = 7'b0110011;
  localparam logic [6:0]        c_OP_IMM   = 7'b0010011;
  localparam logic [6:0]        c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0]        c_OP_JALR  = 7'b1100111;
  localparam logic [6:0]        c_OP_STORE = 7'b0100011;
  localparam logic [6:0]        c_OP_BR    = 7'b1100011;
  localparam logic [6:0]        c_OP_LUI   = 7'b0110111;
  localparam logic [6:0]        c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0]        c_OP_JAL   = 7'b1101111;
  localparam logic [DWIDTH-1:0] c_NOP      = 32'h0000_0013;

  logic [DWIDTH-1:0] w_insn;
  logic              w_err;
  logic              w_ok12;
  logic              w_ok13;
  logic              w_ok21;
  logic [DWIDTH-12:0] w_hi12;
  logic [DWIDTH-13:0] w_hi13;
  logic [DWIDTH-21:0] w_hi21;

  // An immediate fits in N bits when every bit from N-1 upward agrees.
  assign w_hi12 = imm_i[DWIDTH-1:11];
  assign w_hi13 = imm_i[DWIDTH-1:12];
  assign w_hi21 = imm_i[DWIDTH-1:20];
  assign w_ok12 = (&w_hi12) | ~(|w_hi12);
  assign w_ok13 = (&w_hi13) | ~(|w_hi13);
  assign w_ok21 = (&w_hi21) | ~(|w_hi21);

  always_comb begin
    w_insn = c_NOP;
    w_err  = 1'b0;
    case (opcode_i)
      c_OP_R: begin
        w_insn = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      c_OP_IMM: begin
        if (funct3_i == 3'd1 || funct3_i == 3'd5) begin
          w_insn = {funct7_i, shamt_i, rs1_i, funct3_i, rd_i, opcode_i};
          if (funct3_i == 3'd1) w_err = (funct7_i != 7'h00);
          else                  w_err = (funct7_i != 7'h00) && (funct7_i != 7'h20);
        end else begin
          w_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
          w_err  = ~w_ok12;
        end
      end
      c_OP_LOAD, c_OP_JALR: begin
        w_insn = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        w_err  = ~w_ok12;
      end
      c_OP_STORE: begin
        w_insn = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        w_err  = ~w_ok12;
      end
      c_OP_BR: begin
        w_insn = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        w_err  = ~w_ok13 | imm_i[0];
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_insn = {imm_i[31:12], rd_i, opcode_i};
        w_err  = |imm_i[11:0];
      end
      c_OP_JAL: begin
        w_insn = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        w_err  = ~w_ok21 | imm_i[0];
      end
      default: begin
        w_insn = c_NOP;
        w_err  = 1'b1;
      end
    endcase
  end

  logic [AWIDTH-1:0]   r_pc;
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic [1:0]          r_count;
  logic                r_head;
  logic [AWIDTH-1:0]   r_q_pc   [0:1];
  logic [DWIDTH-1:0]   r_q_insn [0:1];
  logic                r_q_err  [0:1];
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic                w_wr_idx;

  assign in_ready_o = rst & ~flush_i & (r_count < 2'd2);
  assign w_valid    = rst & (r_count != 2'd0);
  assign w_push     = in_valid_i & in_ready_o;
  assign w_pop      = w_valid & out_ready_i;
  assign w_wr_idx   = r_head ^ r_count[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= 2'd0;
      r_head    <= 1'b0;
      r_pc      <= BASE_ADDR;
      r_err_cnt <= '0;
    end else if (flush_i) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_pc    <= BASE_ADDR;
    end else begin
      if (w_push) begin
        r_q_pc[w_wr_idx]   <= r_pc;
        r_q_insn[w_wr_idx] <= w_insn;
        r_q_err[w_wr_idx]  <= w_err;
        r_pc               <= r_pc + AWIDTH'(4);
        if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
      end
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign out_valid_o = w_valid;
  assign pc_o        = w_valid ? r_q_pc[r_head]   : '0;
  assign insn_o      = w_valid ? r_q_insn[r_head] : '0;
  assign err_o       = w_valid ? r_q_err[r_head]  : 1'b0;
  assign err_cnt_o   = r_err_cnt;

endmodule

`default_nettype wire
